// File: rtl/ps_lane_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps_lane_arbiter_pkg
//  Description : Shared constants and types for the two-lane byte arbiter
//                that feeds the parallel-to-serial converter.
//  Revision    : 1.0  initial release
// ============================================================================
package ps_lane_arbiter_pkg;

    // Filler / sync symbol driven whenever no payload byte is present
    localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'hBC;

    // FSM encoding
    localparam logic [0:0] ST_SYNC = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Lane identifiers
    typedef logic lane_t;
    localparam lane_t LANE0 = 1'b0;
    localparam lane_t LANE1 = 1'b1;

    // The lane that is not l
    function automatic lane_t other_lane(input lane_t l);
        return ~l;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps_lane_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps_lane_arbiter_if
//  Description : Requester handshakes, converter-side byte bus and status
//                of the two-lane byte arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface ps_lane_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    import ps_lane_arbiter_pkg::*;

    logic [DATA_W-1:0] req0_data;
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req1_data;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    lane_t             lane_out;
    logic              sync_done;
    logic [CNT_W-1:0]  cnt0;
    logic [CNT_W-1:0]  cnt1;

    // Requester / observer side
    modport master (
        output req0_data, req0_valid, req1_data, req1_valid,
        input  req0_ready, req1_ready,
        input  data_out, valid_out, lane_out, sync_done, cnt0, cnt1
    );

    // Arbiter side
    modport slave (
        input  req0_data, req0_valid, req1_data, req1_valid,
        output req0_ready, req1_ready,
        output data_out, valid_out, lane_out, sync_done, cnt0, cnt1
    );

endinterface
`default_nettype wire

// File: rtl/ps_lane_arbiter_rr_grant.sv
`default_nettype none
// ============================================================================
//  Module      : ps_lane_arbiter_rr_grant
//  Description : Combinational round-robin grant with a burst limit for two
//                byte lanes.
//  Revision    : 1.0  initial release
// ============================================================================
module ps_lane_arbiter_rr_grant
    import ps_lane_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int BCNT_W    = 3
) (
    input  wire logic [1:0]        valid,
    input  wire lane_t             last,
    input  wire logic [BCNT_W-1:0] bcnt,
    output logic                   grant_vld,
    output lane_t                  grant
);

    localparam logic [BCNT_W-1:0] C_BCNT_MAX = BCNT_W'(MAX_BURST);

    // Pick a lane: a lone requester always wins; on a tie the lane holding a
    // burst in progress keeps it until the limit. bcnt==0 means no burst is
    // running (after reset or an idle cycle), so the tie alternates away from
    // last -- with last resetting to lane 1 the first tie goes to lane 0.
    always_comb begin
        grant_vld = |valid;
        grant     = LANE0;
        case (valid)
            2'b01:   grant = LANE0;
            2'b10:   grant = LANE1;
            2'b11:   grant = ((bcnt != '0) && (bcnt < C_BCNT_MAX)) ? last : other_lane(last);
            default: grant = LANE0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ps_lane_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ps_lane_arbiter
//  Description : Shares one parallel-to-serial converter between two byte
//                requesters. Emits an IDLE_BYTE sync preamble after reset,
//                then grants round-robin with a burst limit, registering the
//                accepted byte onto the converter input one cycle later.
//  Revision    : 1.0  initial release
// ============================================================================
module ps_lane_arbiter
    import ps_lane_arbiter_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] IDLE_BYTE  = DATA_W'(IDLE_BYTE_DEFAULT),
    parameter int                SYNC_COUNT = 4,
    parameter int                MAX_BURST  = 4,
    parameter int                CNT_W      = 16
) (
    input  wire logic         clk_4f,
    input  wire logic         reset,
    ps_lane_arbiter_if.slave  bus
);

    localparam int SYNC_W = (SYNC_COUNT > 1) ? $clog2(SYNC_COUNT) : 1;
    localparam int BCNT_W = $clog2(MAX_BURST + 1);
    localparam logic [SYNC_W-1:0] C_SYNC_LAST = SYNC_W'(SYNC_COUNT - 1);
    localparam logic [BCNT_W-1:0] C_BCNT_MAX  = BCNT_W'(MAX_BURST);
    localparam logic [BCNT_W-1:0] C_BCNT_ONE  = BCNT_W'(1);

    logic [0:0]        r_state;
    logic [0:0]        w_state_next;
    logic [SYNC_W-1:0] r_sync_cnt;
    lane_t             r_last;
    logic [BCNT_W-1:0] r_bcnt;
    logic              w_grant_vld;
    lane_t             w_grant;
    logic              w_ready0;
    logic              w_ready1;
    logic              w_acc0;
    logic              w_acc1;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    lane_t             r_lane;
    logic [CNT_W-1:0]  r_cnt0;
    logic [CNT_W-1:0]  r_cnt1;

    ps_lane_arbiter_rr_grant #(
        .MAX_BURST (MAX_BURST),
        .BCNT_W    (BCNT_W)
    ) u_rr_grant (
        .valid     ({bus.req1_valid, bus.req0_valid}),
        .last      (r_last),
        .bcnt      (r_bcnt),
        .grant_vld (w_grant_vld),
        .grant     (w_grant)
    );

    // FSM state register
    always_ff @(posedge clk_4f) begin
        if (reset) r_state <= ST_SYNC;
        else       r_state <= w_state_next;
    end

    // FSM next state: leave the preamble after SYNC_COUNT cycles, then RUN until reset
    always_comb begin
        w_state_next = r_state;
        if ((r_state == ST_SYNC) && (r_sync_cnt == C_SYNC_LAST))
            w_state_next = ST_RUN;
    end

    // FSM outputs: readies only in RUN and only for the granted lane
    always_comb begin
        w_ready0 = 1'b0;
        w_ready1 = 1'b0;
        if ((r_state == ST_RUN) && w_grant_vld) begin
            w_ready0 = (w_grant == LANE0);
            w_ready1 = (w_grant == LANE1);
        end
    end

    assign w_acc0 = bus.req0_valid && w_ready0;
    assign w_acc1 = bus.req1_valid && w_ready1;

    // Preamble length counter
    always_ff @(posedge clk_4f) begin
        if (reset)                  r_sync_cnt <= '0;
        else if (r_state == ST_SYNC) r_sync_cnt <= r_sync_cnt + 1'b1;
    end

    // Burst tracking: count consecutive grants to the same lane, saturating at the limit
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            r_last <= LANE1;
            r_bcnt <= '0;
        end else if (r_state == ST_RUN) begin
            if (!w_grant_vld) begin
                r_bcnt <= '0;
            end else if (w_grant == r_last) begin
                r_bcnt <= (r_bcnt == C_BCNT_MAX) ? r_bcnt : r_bcnt + 1'b1;
            end else begin
                r_last <= w_grant;
                r_bcnt <= C_BCNT_ONE;
            end
        end
    end

    // Converter-side output register: accepted byte one cycle later, else filler
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            r_data  <= IDLE_BYTE;
            r_valid <= 1'b0;
            r_lane  <= LANE0;
        end else if (w_acc0) begin
            r_data  <= bus.req0_data;
            r_valid <= 1'b1;
            r_lane  <= LANE0;
        end else if (w_acc1) begin
            r_data  <= bus.req1_data;
            r_valid <= 1'b1;
            r_lane  <= LANE1;
        end else begin
            r_data  <= IDLE_BYTE;
            r_valid <= 1'b0;
            r_lane  <= LANE0;
        end
    end

    // Per-lane accepted-byte statistics, wrapping silently
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_acc0) r_cnt0 <= r_cnt0 + 1'b1;
            if (w_acc1) r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.data_out   = r_data;
    assign bus.valid_out  = r_valid;
    assign bus.lane_out   = r_lane;
    assign bus.sync_done  = (r_state == ST_RUN);
    assign bus.cnt0       = r_cnt0;
    assign bus.cnt1       = r_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_ps_lane_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps_lane_arbiter
//  Description : Directed self-checking bench for ps_lane_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ps_lane_arbiter;

    logic clk_4f = 1'b0;
    logic reset  = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    ps_lane_arbiter_if #(.DATA_W(8), .CNT_W(16)) bus ();

    ps_lane_arbiter #(
        .DATA_W     (8),
        .IDLE_BYTE  (8'hBC),
        .SYNC_COUNT (4),
        .MAX_BURST  (4),
        .CNT_W      (16)
    ) dut (
        .clk_4f (clk_4f),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_4f = ~clk_4f;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk_4f);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset;
        bus.req0_data = 8'hA0; bus.req1_data = 8'hB0;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        reset = 1'b1;
        step; step;
        if (bus.data_out !== 8'hBC) begin n_errors++; $display("FAIL rst_data got %h exp bc", bus.data_out); end
        n_checks++;
        if (bus.valid_out !== 1'b0) begin n_errors++; $display("FAIL rst_valid got %b exp 0", bus.valid_out); end
        n_checks++;
        if (bus.lane_out !== 1'b0) begin n_errors++; $display("FAIL rst_lane got %b exp 0", bus.lane_out); end
        n_checks++;
        if (bus.sync_done !== 1'b0) begin n_errors++; $display("FAIL rst_sync_done got %b exp 0", bus.sync_done); end
        n_checks++;
        if (bus.cnt0 !== 16'h0 || bus.cnt1 !== 16'h0) begin
            n_errors++; $display("FAIL rst_cnt got %h/%h exp 0000/0000", bus.cnt0, bus.cnt1);
        end
        n_checks++;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
                n_errors++; $display("FAIL sync_ready cyc %0d got %b%b exp 00", i, bus.req1_ready, bus.req0_ready);
            end
            n_checks++;
            step;
            if (bus.valid_out !== 1'b0 || bus.data_out !== 8'hBC) begin
                n_errors++; $display("FAIL sync_idle cyc %0d got %b/%h exp 0/bc", i, bus.valid_out, bus.data_out);
            end
            n_checks++;
            if (bus.sync_done !== (i == 3)) begin
                n_errors++; $display("FAIL sync_done cyc %0d got %b exp %b", i, bus.sync_done, (i == 3));
            end
            n_checks++;
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        #1;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            n_errors++; $display("FAIL idle_ready got %b%b exp 00", bus.req1_ready, bus.req0_ready);
        end
        n_checks++;
        step;
        if (bus.valid_out !== 1'b0 || bus.data_out !== 8'hBC) begin
            n_errors++; $display("FAIL idle_out got %b/%h exp 0/bc", bus.valid_out, bus.data_out);
        end
        n_checks++;
    endtask

    task automatic test_single_lane;
        bus.req0_data = 8'hFF; bus.req0_valid = 1'b1;
        #1;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            n_errors++; $display("FAIL single_ready got %b%b exp 01", bus.req1_ready, bus.req0_ready);
        end
        n_checks++;
        step;
        if (bus.data_out !== 8'hFF || bus.valid_out !== 1'b1 || bus.lane_out !== 1'b0 || bus.cnt0 !== 16'd1) begin
            n_errors++; $display("FAIL single_ff got %h/%b/%b/%h exp ff/1/0/0001", bus.data_out, bus.valid_out, bus.lane_out, bus.cnt0);
        end
        n_checks++;
        bus.req0_data = 8'hEE;
        step;
        if (bus.data_out !== 8'hEE || bus.valid_out !== 1'b1 || bus.lane_out !== 1'b0 || bus.cnt0 !== 16'd2) begin
            n_errors++; $display("FAIL single_ee got %h/%b/%b/%h exp ee/1/0/0002", bus.data_out, bus.valid_out, bus.lane_out, bus.cnt0);
        end
        n_checks++;
        bus.req0_valid = 1'b0;
        step;
        if (bus.data_out !== 8'hBC || bus.valid_out !== 1'b0 || bus.lane_out !== 1'b0 || bus.cnt1 !== 16'd0) begin
            n_errors++; $display("FAIL single_after got %h/%b/%b/%h exp bc/0/0/0000", bus.data_out, bus.valid_out, bus.lane_out, bus.cnt1);
        end
        n_checks++;
    endtask

    task automatic test_burst;
        logic [7:0] exp_seq [12] = '{8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2,
                                     8'hB3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hB4};
        logic [7:0] e;
        logic       rd0, rd1;
        int         idx0 = 1;
        int         idx1 = 0;
        // one lone lane-0 byte starts a lane-0 burst, then both lanes stay valid
        bus.req0_data = 8'hA0; bus.req0_valid = 1'b1; bus.req1_valid = 1'b0;
        step;
        if (bus.data_out !== 8'hA0 || bus.lane_out !== 1'b0) begin
            n_errors++; $display("FAIL burst_first got %h/%b exp a0/0", bus.data_out, bus.lane_out);
        end
        n_checks++;
        for (int i = 0; i < 12; i++) begin
            bus.req0_data = 8'hA0 + 8'(idx0);
            bus.req1_data = 8'hB0 + 8'(idx1);
            bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
            #1;
            rd0 = bus.req0_ready; rd1 = bus.req1_ready;
            step;
            if (rd0) idx0++;
            if (rd1) idx1++;
            e = exp_seq[i];
            if (bus.data_out !== e || bus.valid_out !== 1'b1 || bus.lane_out !== (e[7:4] == 4'hB)) begin
                n_errors++; $display("FAIL burst_seq %0d got %h/%b/%b exp %h/1/%b", i, bus.data_out, bus.valid_out, bus.lane_out, e, (e[7:4] == 4'hB));
            end
            n_checks++;
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        step;
        if (bus.valid_out !== 1'b0 || bus.cnt0 !== 16'd10 || bus.cnt1 !== 16'd5) begin
            n_errors++; $display("FAIL burst_cnt got %b/%h/%h exp 0/000a/0005", bus.valid_out, bus.cnt0, bus.cnt1);
        end
        n_checks++;
    endtask

    task automatic test_hold;
        logic [7:0] exp_seq [5] = '{8'h11, 8'h12, 8'h13, 8'h5A, 8'h14};
        logic       rd0, rd1;
        logic       taken1 = 1'b0;
        int         idx0 = 1;
        int         n5a = 0;
        bus.req0_data = 8'h10; bus.req0_valid = 1'b1; bus.req1_valid = 1'b0;
        step;
        if (bus.data_out !== 8'h10) begin n_errors++; $display("FAIL hold_first got %h exp 10", bus.data_out); end
        n_checks++;
        for (int i = 0; i < 5; i++) begin
            bus.req0_data = 8'h10 + 8'(idx0);
            bus.req1_data = 8'h5A;
            bus.req1_valid = !taken1;
            #1;
            rd0 = bus.req0_ready; rd1 = bus.req1_ready;
            if (rd1 !== (i == 3)) begin
                n_errors++; $display("FAIL hold_ready1 cyc %0d got %b exp %b", i, rd1, (i == 3));
            end
            n_checks++;
            step;
            if (rd0) idx0++;
            if (rd1) taken1 = 1'b1;
            if (bus.valid_out && bus.data_out == 8'h5A) n5a++;
            if (bus.data_out !== exp_seq[i]) begin
                n_errors++; $display("FAIL hold_seq %0d got %h exp %h", i, bus.data_out, exp_seq[i]);
            end
            n_checks++;
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        step;
        if (bus.valid_out && bus.data_out == 8'h5A) n5a++;
        if (n5a != 1) begin n_errors++; $display("FAIL hold_once got %0d exp 1", n5a); end
        n_checks++;
        if (bus.cnt0 !== 16'd15 || bus.cnt1 !== 16'd6) begin
            n_errors++; $display("FAIL hold_cnt got %h/%h exp 000f/0006", bus.cnt0, bus.cnt1);
        end
        n_checks++;
    endtask

    task automatic test_reset_mid;
        bus.req0_data = 8'hC0; bus.req1_data = 8'hD0;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        step; step; step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        if (bus.valid_out !== 1'b0 || bus.data_out !== 8'hBC || bus.lane_out !== 1'b0) begin
            n_errors++; $display("FAIL mid_out got %b/%h/%b exp 0/bc/0", bus.valid_out, bus.data_out, bus.lane_out);
        end
        n_checks++;
        if (bus.cnt0 !== 16'h0 || bus.cnt1 !== 16'h0 || bus.sync_done !== 1'b0) begin
            n_errors++; $display("FAIL mid_cnt got %h/%h/%b exp 0000/0000/0", bus.cnt0, bus.cnt1, bus.sync_done);
        end
        n_checks++;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
                n_errors++; $display("FAIL mid_sync_ready cyc %0d got %b%b exp 00", i, bus.req1_ready, bus.req0_ready);
            end
            n_checks++;
            step;
            if (bus.valid_out !== 1'b0 || bus.data_out !== 8'hBC || bus.sync_done !== (i == 3)) begin
                n_errors++; $display("FAIL mid_sync cyc %0d got %b/%h/%b exp 0/bc/%b", i, bus.valid_out, bus.data_out, bus.sync_done, (i == 3));
            end
            n_checks++;
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        step;
        if (bus.valid_out !== 1'b0 || bus.cnt0 !== 16'h0 || bus.cnt1 !== 16'h0) begin
            n_errors++; $display("FAIL mid_after got %b/%h/%h exp 0/0000/0000", bus.valid_out, bus.cnt0, bus.cnt1);
        end
        n_checks++;
    endtask

    task automatic test_wrap;
        bus.req1_data = 8'h77; bus.req1_valid = 1'b1;
        step;
        if (bus.data_out !== 8'h77 || bus.lane_out !== 1'b1 || bus.cnt1 !== 16'd1) begin
            n_errors++; $display("FAIL wrap_l1 got %h/%b/%h exp 77/1/0001", bus.data_out, bus.lane_out, bus.cnt1);
        end
        n_checks++;
        bus.req1_valid = 1'b0;
        bus.req0_data = 8'h33; bus.req0_valid = 1'b1;
        repeat (65535) step;
        if (bus.cnt0 !== 16'hFFFF || bus.cnt1 !== 16'd1) begin
            n_errors++; $display("FAIL wrap_full got %h/%h exp ffff/0001", bus.cnt0, bus.cnt1);
        end
        n_checks++;
        step;
        if (bus.cnt0 !== 16'h0000 || bus.cnt1 !== 16'd1 || bus.valid_out !== 1'b1 || bus.lane_out !== 1'b0) begin
            n_errors++; $display("FAIL wrap_zero got %h/%h/%b/%b exp 0000/0001/1/0", bus.cnt0, bus.cnt1, bus.valid_out, bus.lane_out);
        end
        n_checks++;
        bus.req0_valid = 1'b0;
        step;
    endtask

    initial begin
        bus.req0_data = 8'h00; bus.req1_data = 8'h00;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        test_reset;
        test_single_lane;
        test_burst;
        test_hold;
        test_reset_mid;
        test_wrap;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
